onchip_memory_pipelined: RTL and testbench

ONCHIP_MEMORY_PIPELINED -- requirements
Module: onchip_memory_pipelined

---
 rtl/onchip_memory_pipelined.sv | 165 ++++++++++++++++
 tb/tb_onchip_memory_pipelined.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_pipelined.sv
// ---------------------------------------------------------------------------
// onchip_memory_pipelined
//   Single-port on-chip RAM behind an Avalon-MM style slave with pipelined
//   reads (1 or 2 cycles of latency), per-byte write enables, and sticky
//   error flags for out-of-range and simultaneous read+write commands.
//
// Ports
//   clk            : the only clock, rising edge
//   reset          : synchronous, active-high reset
//   address        : word address (ADDR_W bits)
//   byteenable     : per-byte write enable (DATA_W/8 bits)
//   chipselect     : slave select
//   read / write   : command strobes
//   writedata      : write data (DATA_W bits)
//   clken          : command clock enable (gates acceptance only)
//   reset_req      : memory-protect request, blocks commands while high
//   waitrequest    : combinational, high whenever a command cannot be taken
//   readdata       : registered read data, held between valid pulses
//   readdatavalid  : one-cycle pulse per accepted read
//   range_err      : sticky, set by any accepted access with address >= DEPTH
//   proto_err      : sticky, set by an accepted read+write in the same cycle
// ---------------------------------------------------------------------------
module onchip_memory_pipelined #(
   parameter int    DATA_W       = 32,
   parameter int    ADDR_W       = 13,
   parameter int    DEPTH        = 6500,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = ""
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W-1:0]     writedata,
   input  logic                  clken,
   input  logic                  reset_req,
   output logic                  waitrequest,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   output logic                  range_err,
   output logic                  proto_err
);

   localparam int              NUM_BYTES = DATA_W / 8;
   // One extra bit so that DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] LP_DEPTH  = DEPTH[ADDR_W:0];

   // Elaboration-time parameter sanity checks.
   if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 128) begin : g_bad_data_w
      $error("DATA_W must be a multiple of 8 in 8..128");
   end
   if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
      $error("DEPTH must not exceed 2**ADDR_W");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_accept;
   logic              w_rd_accept;
   logic              w_wr_accept;
   logic              w_in_range;

   logic              r_s1_valid;
   logic [DATA_W-1:0] r_s1_data;
   logic              r_range_err;
   logic              r_proto_err;

   // ------------------------------------------------------------------
   // Command acceptance. Only acceptance is gated by clken/reset_req;
   // the read pipeline below keeps advancing every cycle.
   // ------------------------------------------------------------------
   assign waitrequest = ~(clken & ~reset_req);
   assign w_accept    = chipselect & ~waitrequest & ~reset;
   assign w_in_range  = ({1'b0, address} < LP_DEPTH);
   assign w_wr_accept = w_accept & write;
   // A read paired with a write is discarded; the write still happens.
   assign w_rd_accept = w_accept & read & ~write;

   // ------------------------------------------------------------------
   // Storage array with per-byte write enables.
   // NOTE: the array has no reset branch on purpose: contents must survive
   // reset, and a reset on a RAM prevents block-RAM inference.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wr_accept && w_in_range) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (byteenable[i]) begin
               r_mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read stage 1 (RAM output). Data only moves on an accepted read so
   // the value is held between pulses; out-of-range reads return zero.
   // NOTE: sequential state is assigned with <= so every register samples
   // the pre-edge values regardless of statement order.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_s1_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_s1_data <= w_in_range ? r_mem[address] : '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Sticky error flags, cleared only by reset.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_range_err <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_accept && (read || write) && !w_in_range) begin
            r_range_err <= 1'b1;
         end
         if (w_accept && read && write) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign range_err = r_range_err;
   assign proto_err = r_proto_err;

   // ------------------------------------------------------------------
   // Output stage. Latency 2 adds one register behind the RAM stage with
   // the valid bit travelling alongside the data.
   // ------------------------------------------------------------------
   if (READ_LATENCY == 2) begin : g_lat2
      logic              r_s2_valid;
      logic [DATA_W-1:0] r_s2_data;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
         end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_data <= r_s1_data;
            end
         end
      end

      assign readdata      = r_s2_data;
      assign readdatavalid = r_s2_valid;
   end else begin : g_lat1
      assign readdata      = r_s1_data;
      assign readdatavalid = r_s1_valid;
   end

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// ---------------------------------------------------------------------------
// tb_onchip_memory_pipelined
//   Drives one command stream into two instances (READ_LATENCY 1 and 2).
//   Expected read results, with the cycle they are due, are queued when a
//   read is issued and popped by a per-instance monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_onchip_memory_pipelined;

   localparam int DW    = 32;
   localparam int AW    = 13;
   localparam int DEPTH = 6500;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [AW-1:0]   address;
   logic [DW/8-1:0] byteenable;
   logic            chipselect;
   logic            read;
   logic            write;
   logic [DW-1:0]   writedata;
   logic            clken;
   logic            reset_req;

   logic            waitrequest [2];
   logic [DW-1:0]   readdata    [2];
   logic            readdatavalid [2];
   logic            range_err   [2];
   logic            proto_err   [2];

   exp_t            exp_q [2][$];
   int              lat   [2] = '{1, 2};
   logic [DW-1:0]   model [int];
   int              cyc      = 0;
   int              n_checks = 0;
   int              n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   onchip_memory_pipelined #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut_lat1 (
      .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .waitrequest(waitrequest[0]),
      .readdata(readdata[0]), .readdatavalid(readdatavalid[0]),
      .range_err(range_err[0]), .proto_err(proto_err[0])
   );

   onchip_memory_pipelined #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) u_dut_lat2 (
      .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .waitrequest(waitrequest[1]),
      .readdata(readdata[1]), .readdatavalid(readdatavalid[1]),
      .range_err(range_err[1]), .proto_err(proto_err[1])
   );

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] model_rd(input int a);
      return model.exists(a) ? model[a] : '0;
   endfunction

   // One command cycle: apply at the falling edge, predict its effect.
   task automatic drive(input logic cs, input logic rd, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW/8-1:0] be, input logic ck = 1'b1,
                        input logic rq = 1'b0, input logic rst = 1'b0);
      logic          acc;
      logic [DW-1:0] word;
      int            a;
      @(negedge clk);
      chipselect = cs;  read = rd;  write = wr;  address = addr;
      writedata  = wd;  byteenable = be;  clken = ck;  reset_req = rq;  reset = rst;
      a   = int'(addr);
      acc = cs & ck & ~rq & ~rst;
      if (acc && wr && a < DEPTH) begin
         word = model_rd(a);
         for (int i = 0; i < DW/8; i++) begin
            if (be[i]) word[i*8 +: 8] = wd[i*8 +: 8];
         end
         model[a] = word;
      end
      if (acc && rd && !wr) begin
         for (int k = 0; k < 2; k++) begin
            exp_q[k].push_back('{data: (a < DEPTH) ? model_rd(a) : '0, due: cyc + lat[k]});
         end
      end
      // A reset edge kills any pulse that would appear at or after it.
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = exp_q[k].size() - 1; i >= 0; i--) begin
               if (exp_q[k][i].due >= cyc + 1) exp_q[k].delete(i);
            end
         end
      end
   endtask

   task automatic idle(input int n, input logic ck = 1'b1, input logic rq = 1'b0,
                       input logic rst = 1'b0);
      repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, ck, rq, rst);
   endtask

   task automatic wr_cmd(input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] be);
      drive(1'b1, 1'b0, 1'b1, addr, wd, be);
   endtask

   task automatic rd_cmd(input logic [AW-1:0] addr);
      drive(1'b1, 1'b1, 1'b0, addr, '0, '0);
   endtask

   task automatic check_flags(input string tag, input logic re, input logic pe);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_range_err_lat%0d", tag, lat[k]), {31'b0, range_err[k]}, {31'b0, re});
         check($sformatf("%s_proto_err_lat%0d", tag, lat[k]), {31'b0, proto_err[k]}, {31'b0, pe});
      end
   endtask

   task automatic check_wait(input string tag, input logic exp);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_waitrequest_lat%0d", tag, lat[k]), {31'b0, waitrequest[k]}, {31'b0, exp});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_readdatavalid_lat%0d", tag, lat[k]), {31'b0, readdatavalid[k]}, '0);
         check($sformatf("%s_readdata_lat%0d", tag, lat[k]), readdata[k], '0);
      end
   endtask

   // Scoreboard monitor: a pulse must appear exactly when the head entry is due.
   task automatic mon(input int k, input logic v, input logic [DW-1:0] d);
      exp_t e;
      if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
         e = exp_q[k].pop_front();
         check($sformatf("readdatavalid_lat%0d_due%0d", lat[k], e.due), {31'b0, v}, 32'd1);
         if (v === 1'b1) check($sformatf("readdata_lat%0d_due%0d", lat[k], e.due), d, e.data);
      end else if (v === 1'b1) begin
         check($sformatf("unexpected_readdatavalid_lat%0d", lat[k]), {31'b0, v}, '0);
      end
   endtask

   always @(negedge clk) begin
      mon(0, readdatavalid[0], readdata[0]);
      mon(1, readdatavalid[1], readdata[1]);
   end

   initial begin
      reset = 1'b1;  chipselect = 1'b0;  read = 1'b0;  write = 1'b0;
      address = '0;  writedata = '0;  byteenable = '0;  clken = 1'b1;  reset_req = 1'b0;

      // Reset state
      idle(3, 1'b1, 1'b0, 1'b1);
      idle(1);
      check_reset_outputs("por");
      check_flags("por", 1'b0, 1'b0);
      check_wait("por", 1'b0);

      // Full write then immediate read of the same address
      wr_cmd(13'd5, 32'hDEAD_BEEF, 4'hF);
      rd_cmd(13'd5);
      idle(3);

      // Partial (single byte) overwrite
      wr_cmd(13'd5, 32'h0000_00AA, 4'h1);
      rd_cmd(13'd5);
      idle(3);

      // Back-to-back reads draining while clken is low
      wr_cmd(13'd1, 32'h11, 4'hF);
      wr_cmd(13'd2, 32'h22, 4'hF);
      wr_cmd(13'd3, 32'h33, 4'hF);
      rd_cmd(13'd1);
      rd_cmd(13'd2);
      rd_cmd(13'd3);
      idle(1, 1'b0);
      check_wait("clken_low", 1'b1);
      idle(3, 1'b0);

      // Address boundaries: last valid word, first invalid word
      wr_cmd(13'd6499, 32'hCAFE_F00D, 4'hF);
      rd_cmd(13'd6499);
      idle(3);
      check_flags("last_word", 1'b0, 1'b0);
      rd_cmd(13'd6500);
      idle(3);
      check_flags("read_6500", 1'b1, 1'b0);
      wr_cmd(13'd7000, 32'h7777_7777, 4'hF);
      rd_cmd(13'd7000);
      idle(3);

      // Reset clears flags and output, keeps array contents
      idle(2, 1'b1, 1'b0, 1'b1);
      idle(1);
      check_reset_outputs("rst1");
      check_flags("rst1", 1'b0, 1'b0);
      rd_cmd(13'd5);
      rd_cmd(13'd6499);
      idle(3);

      // Simultaneous read and write: write lands, read is dropped
      drive(1'b1, 1'b1, 1'b1, 13'd9, 32'h55, 4'hF);
      idle(3);
      check_flags("rw_same", 1'b0, 1'b1);
      rd_cmd(13'd9);
      idle(3);

      // reset_req blocks a write
      drive(1'b1, 1'b0, 1'b1, 13'd5, 32'h1234_5678, 4'hF, 1'b1, 1'b1);
      check_wait("reset_req", 1'b1);
      rd_cmd(13'd5);
      idle(3);

      // Reset right after a read; a write presented during reset is ignored
      rd_cmd(13'd1);
      drive(1'b1, 1'b0, 1'b1, 13'd2, 32'h99, 4'hF, 1'b1, 1'b0, 1'b1);
      idle(1);
      check_reset_outputs("rst_mid");
      check_flags("rst_mid", 1'b0, 1'b0);
      idle(2);
      rd_cmd(13'd2);
      rd_cmd(13'd3);
      idle(4);

      // Every queued read must have been returned
      for (int k = 0; k < 2; k++) begin
         check($sformatf("pending_reads_lat%0d", lat[k]), exp_q[k].size(), '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
